// File: rtl/vpu_dst_port_v2.sv
// vpu_dst_port_v2: buffered write-back port turning lane beats into strided, lane-masked SRAM writes
module vpu_dst_port_v2 #(
   parameter int VLANE_CNT     = 8,
   parameter int OPERAND_WIDTH = 32,
   parameter int ADDR_WIDTH    = 16,
   parameter int LEN_WIDTH     = 16,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               reset_cmd_i,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   input  logic [ADDR_WIDTH-1:0]              req_base_addr_i,
   input  logic [ADDR_WIDTH-1:0]              req_stride_i,
   input  logic [LEN_WIDTH-1:0]               req_len_i,
   input  logic [VLANE_CNT-1:0]               req_lane_mask_i,
   input  logic                               wb_valid_i,
   output logic                               wb_ready_o,
   input  logic [OPERAND_WIDTH*VLANE_CNT-1:0] wb_data_i,
   output logic                               sram_wren_o,
   input  logic                               sram_wready_i,
   output logic [ADDR_WIDTH-1:0]              sram_waddr_o,
   output logic [OPERAND_WIDTH*VLANE_CNT-1:0] sram_wdata_o,
   output logic [OPERAND_WIDTH*VLANE_CNT/8-1:0] sram_wbe_o,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               err_o
);
   localparam int DW  = OPERAND_WIDTH*VLANE_CNT;
   localparam int BW  = DW/8;
   localparam int BPL = OPERAND_WIDTH/8;
   localparam int PW  = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr, r_stride;
   logic [LEN_WIDTH-1:0]  r_len, r_acc_cnt, r_wr_cnt;
   logic [VLANE_CNT-1:0]  r_mask;
   logic [DW-1:0]         r_fifo [FIFO_DEPTH];
   logic [PW:0]           r_wptr, r_rptr;
   logic                  r_err;
   logic                  w_run, w_empty, w_full, w_req, w_push, w_pop, w_last;
   logic [BW-1:0]         w_wbe;
   assign w_run   = r_state == RUN;
   assign w_empty = r_wptr == r_rptr;
   assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign w_req   = req_valid_i && req_ready_o;
   assign w_push  = wb_valid_i && wb_ready_o;
   assign w_pop   = sram_wren_o && sram_wready_i;
   assign w_last  = w_pop && (r_wr_cnt == r_len - LEN_WIDTH'(1));
   genvar i;
   for (i = 0; i < VLANE_CNT; i++) begin : g_wbe
      assign w_wbe[i*BPL +: BPL] = {BPL{r_mask[i]}};
   end
   assign req_ready_o  = !w_run;
   assign wb_ready_o   = w_run && !w_full && (r_acc_cnt < r_len);
   assign sram_wren_o  = w_run && !w_empty;
   assign sram_waddr_o = r_addr;
   assign sram_wdata_o = sram_wren_o ? r_fifo[r_rptr[PW-1:0]] : '0;
   assign sram_wbe_o   = sram_wren_o ? w_wbe : '0;
   assign busy_o       = w_run;
   assign done_o       = r_state == DONE;
   assign err_o        = r_err;
   // state register
   always_ff @(posedge clk)
      r_state <= rst ? IDLE : w_next;
   // next state: soft reset wins, then request acceptance, then final write
   always_comb begin
      w_next = r_state;
      if (reset_cmd_i)
         w_next = IDLE;
      else if (w_req)
         w_next = (req_len_i != '0) ? RUN : DONE;
      else if (w_last)
         w_next = DONE;
   end
   // request latching, fifo pointers, beat/write counters, address walk and sticky error
   always_ff @(posedge clk) begin
      if (rst || reset_cmd_i) begin
         r_addr    <= '0;
         r_stride  <= '0;
         r_len     <= '0;
         r_mask    <= '0;
         r_acc_cnt <= '0;
         r_wr_cnt  <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_req) begin
            r_addr    <= req_base_addr_i;
            r_stride  <= req_stride_i;
            r_len     <= req_len_i;
            r_mask    <= req_lane_mask_i;
            r_acc_cnt <= '0;
            r_wr_cnt  <= '0;
         end
         if (w_push) begin
            r_wptr    <= r_wptr + 1'b1;
            r_acc_cnt <= r_acc_cnt + LEN_WIDTH'(1);
         end
         if (w_pop) begin
            r_rptr   <= r_rptr + 1'b1;
            r_wr_cnt <= r_wr_cnt + LEN_WIDTH'(1);
            r_addr   <= r_addr + r_stride;
         end
         if (wb_valid_i && !w_run)
            r_err <= 1'b1;
      end
   end
   // beat storage; contents are only visible through valid pointers so no reset needed
   always_ff @(posedge clk)
      if (w_push && !rst && !reset_cmd_i)
         r_fifo[r_wptr[PW-1:0]] <= wb_data_i;
endmodule

// File: tb/tb_vpu_dst_port_v2.sv
// tb_vpu_dst_port_v2: randomized directed checks of the write-back port against an address/data/mask model
module tb_vpu_dst_port_v2;
   logic         clk = 1'b0;
   logic         rst, reset_cmd_i, req_valid_i, req_ready_o;
   logic [15:0]  req_base_addr_i, req_stride_i, req_len_i;
   logic [7:0]   req_lane_mask_i;
   logic         wb_valid_i, wb_ready_o, sram_wren_o, sram_wready_i;
   logic [255:0] wb_data_i, sram_wdata_o;
   logic [15:0]  sram_waddr_o;
   logic [31:0]  sram_wbe_o;
   logic         busy_o, done_o, err_o;
   int           total = 0;
   int           bad = 0;
   vpu_dst_port_v2 dut (
      .clk(clk), .rst(rst), .reset_cmd_i(reset_cmd_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_base_addr_i(req_base_addr_i), .req_stride_i(req_stride_i),
      .req_len_i(req_len_i), .req_lane_mask_i(req_lane_mask_i),
      .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_data_i(wb_data_i),
      .sram_wren_o(sram_wren_o), .sram_wready_i(sram_wready_i),
      .sram_waddr_o(sram_waddr_o), .sram_wdata_o(sram_wdata_o), .sram_wbe_o(sram_wbe_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] exp_wbe(input logic [7:0] m);
      logic [31:0] w = '0;
      for (int l = 0; l < 8; l++)
         if (m[l]) w[l*4 +: 4] = 4'hF;
      return w;
   endfunction
   function automatic logic [255:0] rnd256();
      logic [255:0] d;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction
   // mode 0: sram always ready, 1: sram stalled for 12 cycles then ready, 2: random ready
   task automatic run_req(input logic [15:0] base, input logic [15:0] stride, input logic [15:0] len,
                          input logic [7:0] mask, input int mode, input bit gaps, input string tag);
      logic [255:0] beats[$];
      logic [15:0]  got_a[$];
      logic [255:0] got_d[$];
      logic [31:0]  got_b[$];
      logic [15:0]  paddr;
      logic [255:0] pdata;
      int sent = 0, nw = 0, cyc = 0, first_acc = -1, first_wren = -1, stall_acc = 0;
      bit pstall = 0;
      for (int k = 0; k < len; k++) beats.push_back(rnd256());
      chk({tag, "_req_ready"}, req_ready_o, 1'b1);
      req_valid_i = 1; req_base_addr_i = base; req_stride_i = stride;
      req_len_i = len; req_lane_mask_i = mask; wb_valid_i = 0;
      @(negedge clk);
      req_valid_i = 0;
      req_base_addr_i = $urandom; req_stride_i = $urandom; req_len_i = $urandom; req_lane_mask_i = $urandom;
      chk({tag, "_done_fall"}, done_o, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b1);
      while (nw < len && cyc < 400) begin
         wb_valid_i = (sent < len) && (!gaps || $urandom_range(0, 3) != 0);
         wb_data_i = (sent < len) ? beats[sent] : rnd256();
         sram_wready_i = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc >= 12) : 1'($urandom_range(0, 1));
         if (pstall) begin
            chk({tag, "_stall_wren"}, sram_wren_o, 1'b1);
            chk({tag, "_stall_addr"}, sram_waddr_o, paddr);
            chk({tag, "_stall_data"}, sram_wdata_o, pdata);
         end
         if (sram_wren_o && first_wren < 0) first_wren = cyc;
         if (wb_valid_i && wb_ready_o) begin
            if (first_acc < 0) first_acc = cyc;
            if (mode == 1 && cyc < 12) stall_acc++;
            sent++;
         end
         if (sram_wren_o && sram_wready_i) begin
            got_a.push_back(sram_waddr_o); got_d.push_back(sram_wdata_o); got_b.push_back(sram_wbe_o);
            nw++;
         end
         pstall = sram_wren_o && !sram_wready_i;
         paddr = sram_waddr_o; pdata = sram_wdata_o;
         @(negedge clk);
         cyc++;
      end
      wb_valid_i = 0; sram_wready_i = 0;
      chk({tag, "_nwrites"}, nw, len);
      chk({tag, "_latency"}, first_wren - first_acc, 1);
      if (mode == 1) chk({tag, "_stall_accepts"}, stall_acc, 4);
      for (int k = 0; k < nw; k++) begin
         chk({tag, "_addr"}, got_a[k], 16'(base + 16'(k) * stride));
         chk({tag, "_data"}, got_d[k], beats[k]);
         chk({tag, "_wbe"}, got_b[k], exp_wbe(mask));
      end
      chk({tag, "_done"}, done_o, 1'b1);
      chk({tag, "_idle_busy"}, busy_o, 1'b0);
      chk({tag, "_done_wren"}, sram_wren_o, 1'b0);
      chk({tag, "_err"}, err_o, 1'b0);
   endtask
   initial begin
      int nw, cyc;
      rst = 1; reset_cmd_i = 0; req_valid_i = 0; req_base_addr_i = 0; req_stride_i = 0;
      req_len_i = 0; req_lane_mask_i = 0; wb_valid_i = 0; wb_data_i = 0; sram_wready_i = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      chk("rst_req_ready", req_ready_o, 1'b1);
      chk("rst_wb_ready", wb_ready_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_wren", sram_wren_o, 1'b0);
      chk("rst_waddr", sram_waddr_o, 16'h0);
      chk("rst_wdata", sram_wdata_o, 256'h0);
      chk("rst_wbe", sram_wbe_o, 32'h0);
      chk("rst_err", err_o, 1'b0);
      run_req(16'h0100, 16'h0001, 16'd4, 8'hFF, 0, 0, "basic");
      run_req(16'h1234, 16'h0002, 16'd8, 8'hFF, 1, 0, "bp");
      run_req(16'hFFF0, 16'h0010, 16'd3, 8'hA3, 0, 0, "wrap");
      run_req(16'h0040, 16'h0003, 16'd5, 8'h05, 2, 1, "mask05");
      // abort after two writes
      req_valid_i = 1; req_base_addr_i = 16'h0300; req_stride_i = 16'h1; req_len_i = 16'd4; req_lane_mask_i = 8'hFF;
      @(negedge clk);
      req_valid_i = 0;
      nw = 0; cyc = 0;
      while (nw < 2 && cyc < 50) begin
         wb_valid_i = 1; wb_data_i = rnd256(); sram_wready_i = 1;
         if (sram_wren_o) nw++;
         @(negedge clk);
         cyc++;
      end
      chk("abort_two_writes", nw, 2);
      wb_valid_i = 0; sram_wready_i = 0; reset_cmd_i = 1;
      @(negedge clk);
      reset_cmd_i = 0;
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_wren", sram_wren_o, 1'b0);
      chk("abort_done", done_o, 1'b0);
      chk("abort_req_ready", req_ready_o, 1'b1);
      chk("abort_err", err_o, 1'b0);
      repeat (3) @(negedge clk);
      chk("abort_flushed", sram_wren_o, 1'b0);
      wb_valid_i = 1;
      @(negedge clk);
      wb_valid_i = 0;
      chk("err_set", err_o, 1'b1);
      @(negedge clk);
      chk("err_sticky", err_o, 1'b1);
      reset_cmd_i = 1;
      @(negedge clk);
      reset_cmd_i = 0;
      chk("err_clear", err_o, 1'b0);
      // zero-length request completes without writing
      req_valid_i = 1; req_base_addr_i = 16'h0500; req_stride_i = 16'h1; req_len_i = 16'd0; req_lane_mask_i = 8'hFF;
      @(negedge clk);
      req_valid_i = 0;
      chk("len0_done", done_o, 1'b1);
      chk("len0_wren", sram_wren_o, 1'b0);
      @(negedge clk);
      chk("len0_hold", done_o, 1'b1);
      run_req(16'h0200, 16'h0001, 16'd2, 8'hFF, 0, 0, "b2b");
      for (int r = 0; r < 6; r++)
         run_req(16'($urandom), 16'($urandom), 16'($urandom_range(1, 10)), 8'($urandom), 2, 1, "rand");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
